// File: rtl/aes_if_pkg.sv
// Shared types and constants for the AES byte-serial host initiator.
// Byte 0 of a 128-bit block sits in bits [127:120].
package aes_if_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4
  } aes_host_state_e;

  function automatic logic [AES_BYTE_W-1:0] byte_of(
    input logic [127:0] blk,
    input logic [3:0]   idx
  );
    logic [127:0] t;
    t = blk << {idx, 3'b000};
    return t[127:120];
  endfunction

endpackage

// File: rtl/aes_block_shreg.sv
// 128-bit block register: parallel load, shift left one byte,
// new byte enters at the low end. Exposes the top OUT_W bits.
module aes_block_shreg
  import aes_if_pkg::*;
#(
  parameter int OUT_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [127:0]          load_val_i,
  input  logic                  shift_i,
  input  logic [AES_BYTE_W-1:0] byte_i,
  output logic [OUT_W-1:0]      q_o
);

  localparam int W = AES_BLOCK_BYTES * AES_BYTE_W;

  logic [W-1:0] q_q;

  // Load has priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shift_i) begin
      q_q <= {q_q[W-AES_BYTE_W-1:0], byte_i};
    end
  end

  assign q_o = q_q[W-1 -: OUT_W];

endmodule

// File: rtl/aes_byte_host_if.sv
// Host-side initiator for the byte-serial AES-128 core: loads key and
// plaintext a byte per cycle, collects 16 ciphertext bytes.
module aes_byte_host_if
  import aes_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 511
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         out_error,
  output logic         busy,
  output logic         core_rst,
  output logic [7:0]   core_key_in,
  output logic [7:0]   core_data_in,
  input  logic [7:0]   core_data_out,
  input  logic         core_data_valid
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);

  aes_host_state_e state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            rdy_q;
  logic            accept;
  logic            ld_shift;
  logic            cap_shift;
  logic            res_clr;
  logic [7:0]      key_top;
  logic [7:0]      dat_top;
  logic [127:0]    res_q;

  assign accept    = in_valid && rdy_q;
  assign ld_shift  = (state_q == ST_LOAD);
  assign cap_shift = core_data_valid &&
                     ((state_q == ST_WAIT) ||
                      (state_q == ST_CAPTURE));

  aes_block_shreg #(.OUT_W(8)) u_key_sr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (in_key),
    .shift_i    (ld_shift),
    .byte_i     (8'h00),
    .q_o        (key_top)
  );

  aes_block_shreg #(.OUT_W(8)) u_dat_sr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (in_block),
    .shift_i    (ld_shift),
    .byte_i     (8'h00),
    .q_o        (dat_top)
  );

  // Result is cleared on accept and on any error so a failed
  // request always presents an all-zero block.
  aes_block_shreg #(.OUT_W(128)) u_res_sr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (res_clr),
    .load_val_i (128'h0),
    .shift_i    (cap_shift),
    .byte_i     (core_data_out),
    .q_o        (res_q)
  );

  // Next-state, byte counter, timeout counter and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    err_d   = err_q;
    res_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          res_clr = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d = cnt_q + 4'd1;
        to_d  = '0;
        if (cnt_q == LAST_BYTE) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        to_d = to_q + TO_W'(1);
        if (core_data_valid) begin
          cnt_d   = 4'd1;
          state_d = ST_CAPTURE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          res_clr = 1'b1;
          state_d = ST_OUTPUT;
        end
      end
      ST_CAPTURE: begin
        if (core_data_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_BYTE) state_d = ST_OUTPUT;
        end else begin
          err_d   = 1'b1;
          res_clr = 1'b1;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; in_ready is registered so it rises one cycle
  // after reset release and drops the cycle after an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == ST_IDLE);
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = (state_q == ST_OUTPUT);
  assign out_error    = err_q;
  assign out_block    = res_q;
  assign busy         = (state_q != ST_IDLE);
  assign core_rst     = !(state_q inside {ST_LOAD, ST_WAIT, ST_CAPTURE});
  assign core_key_in  = ld_shift ? key_top : 8'h00;
  assign core_data_in = ld_shift ? dat_top : 8'h00;

endmodule

// File: tb/tb_aes_byte_host_if.sv
// Bench for aes_byte_host_if with a byte-serial core stub that returns
// FIPS-197 ciphertexts for known pairs and a fixed mix otherwise.
module tb_aes_byte_host_if;
  import aes_if_pkg::*;

  localparam int TO    = 32;
  localparam int LAT   = 3;
  localparam int LIMIT = 300;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] K2 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] P2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] K3 = 128'h8000000000000000000000000000a5c3;
  localparam logic [127:0] P3 = 128'hffffffffffffffff0000000000000001;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         out_error;
  logic         busy;
  logic         core_rst;
  logic [7:0]   core_key_in;
  logic [7:0]   core_data_in;
  logic [7:0]   core_data_out;
  logic         core_data_valid;

  aes_byte_host_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_key          (in_key),
    .in_block        (in_block),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_block       (out_block),
    .out_error       (out_error),
    .busy            (busy),
    .core_rst        (core_rst),
    .core_key_in     (core_key_in),
    .core_data_in    (core_data_in),
    .core_data_out   (core_data_out),
    .core_data_valid (core_data_valid)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int acc_edge = 0;
  int out_edge = 0;
  int prev_out_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Core stub: records 16 load bytes, then after LAT cycles emits
  // 0, 16 or 7 ciphertext bytes depending on cm_mode.
  int          cm_mode = 0;
  int          cm_nb;
  int          lc = 0;
  logic [7:0]  kb[16];
  logic [7:0]  db[16];
  logic [127:0] cm_key, cm_pt, cm_ct;

  function automatic logic [127:0] stub(input logic [127:0] k,
                                        input logic [127:0] p);
    if (k == FK && p == FP) return FC;
    if (k == 128'h0 && p == 128'h0) return ZC;
    return {k[63:0], k[127:64]} ^ p;
  endfunction

  always_comb begin
    cm_key = '0;
    cm_pt  = '0;
    for (int i = 0; i < 16; i++) begin
      cm_key = {cm_key[119:0], kb[i]};
      cm_pt  = {cm_pt[119:0], db[i]};
    end
    cm_ct = stub(cm_key, cm_pt);
    cm_nb = (cm_mode == 0) ? 16 : (cm_mode == 1) ? 0 : 7;
  end

  always @(posedge clk) begin
    if (core_rst) begin
      lc              <= 0;
      core_data_valid <= 1'b0;
      core_data_out   <= 8'h00;
    end else begin
      if (lc < 16) begin
        kb[lc[3:0]] <= core_key_in;
        db[lc[3:0]] <= core_data_in;
      end
      lc <= lc + 1;
      if (lc >= 16 + LAT && lc < 16 + LAT + cm_nb) begin
        core_data_valid <= 1'b1;
        core_data_out   <= byte_of(cm_ct, 4'(lc - 16 - LAT));
      end else begin
        core_data_valid <= 1'b0;
        core_data_out   <= 8'h00;
      end
    end
  end

  // Scoreboard: {block, error} pushed on accept, popped on output.
  logic [128:0] sb_q[$];
  logic [128:0] sb_e;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_edge = cyc + 1;
      if (sb_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_out: got %h err %b", out_block,
                 out_error);
      end else begin
        sb_e = sb_q.pop_front();
        chk("out_block", out_block, sb_e[128:1]);
        chk("out_error", 128'(out_error), 128'(sb_e[0]));
      end
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] p,
                      input logic [127:0] e, input logic ee,
                      input bit hold);
    int n;
    n        = 0;
    in_key   = k;
    in_block = p;
    in_valid = 1'b1;
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_wait: in_ready %b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    prev_out_edge = out_edge;
    acc_edge      = cyc + 1;
    sb_q.push_back({e, ee});
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      nvec++;
      nerr++;
      $display("FAIL out_valid_wait: got 0 want 1");
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    int           mode;
    logic [127:0] exp;
    logic         err;
  } vec_t;

  vec_t tv[6];
  logic [127:0] blk0;
  bit           ok;

  initial begin
    tv[0] = '{FK, FP, 0, FC, 1'b0};
    tv[1] = '{128'h0, 128'h0, 0, ZC, 1'b0};
    tv[2] = '{K2, P2, 0, {K2[63:0], K2[127:64]} ^ P2, 1'b0};
    tv[3] = '{K3, P3, 0, {K3[63:0], K3[127:64]} ^ P3, 1'b0};
    tv[4] = '{FK, FP, 1, 128'h0, 1'b1};
    tv[5] = '{K2, P2, 2, 128'h0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    in_block  = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_ctl", {in_ready, out_valid, out_error, busy, core_rst},
        5'b00001);
    chk("rst_block", out_block, 128'h0);
    chk("rst_core_bytes", {core_key_in, core_data_in}, 16'h0);
    rst = 1'b0;
    #1;
    chk("rdy_at_release", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    chk("rdy_after_release", 128'(in_ready), 128'(1'b1));

    for (int i = 0; i < 6; i++) begin
      cm_mode = tv[i].mode;
      send(tv[i].key, tv[i].pt, tv[i].exp, tv[i].err, 1'b0);
      chk("rdy_busy", {in_ready, busy}, 2'b01);
      wait_drain();
      if (tv[i].mode == 0) begin
        chk("core_key_seq", cm_key, tv[i].key);
        chk("core_data_seq", cm_pt, tv[i].pt);
      end
    end

    cm_mode = 1;
    send(FK, FP, 128'h0, 1'b1, 1'b0);
    wait_ov();
    chk("timeout_latency", 128'(cyc - acc_edge), 128'(16 + TO));
    wait_drain();

    cm_mode = 0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    send(FK, FP, FC, 1'b0, 1'b0);
    wait_ov();
    blk0 = out_block;
    ok   = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid && out_block == blk0 && !in_ready)) ok = 1'b0;
    end
    chk("bp_hold", 128'(ok), 128'(1'b1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rdy_after", 128'(in_ready), 128'(1'b1));
    wait_drain();

    send(FK, FP, FC, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_midload", {in_ready, core_rst, busy, out_valid}, 4'b0100);
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
    send(FK, FP, FC, 1'b0, 1'b0);
    wait_drain();

    send(FK, FP, FC, 1'b0, 1'b1);
    send(128'h0, 128'h0, ZC, 1'b0, 1'b0);
    chk("b2b_gap", 128'(acc_edge - prev_out_edge), 128'(1));
    wait_drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
